// File: rtl/rob_retire_pkg.sv
// Shared types for the reorder buffer: rename payload, retired row and tag type.
package rob_retire_pkg;
    localparam int ROB_DEPTH = 64;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
    localparam int PREG_W    = 7;
    localparam int AREG_W    = 5;

    typedef logic [ROB_TAG_W-1:0] rob_tag;

    typedef struct packed {
        logic [AREG_W-1:0] ArchRegDst;
        logic [PREG_W-1:0] PRegAddrDst;
        logic [PREG_W-1:0] OldPRegAddrDst;
    } rename_struct;

    typedef struct packed {
        logic              valid;
        rob_tag            tag;
        logic [AREG_W-1:0] ArchRegDst;
        logic [PREG_W-1:0] PRegAddrDst;
        logic [PREG_W-1:0] OldPRegAddrDst;
    } rob_row_struct;
endpackage

// File: rtl/rob_retire_select.sv
// Prefix retire selection over the three oldest ROB entries.
module rob_retire_select (
    input  logic [2:0] i_valid,
    input  logic [2:0] i_done,
    output logic [2:0] o_mask,
    output logic [1:0] o_count
);
    logic [2:0] w_ready;

    always_comb begin
        w_ready   = i_valid & i_done;
        // A younger row may only retire when every older row also retires.
        o_mask[0] = w_ready[0];
        o_mask[1] = w_ready[0] & w_ready[1];
        o_mask[2] = w_ready[0] & w_ready[1] & w_ready[2];
        o_count   = {1'b0, o_mask[0]} + {1'b0, o_mask[1]} + {1'b0, o_mask[2]};
    end
endmodule

// File: rtl/rob_retire.sv
// Reorder buffer: 2-wide dispatch, 3-wide writeback, up to 3 in-order retires per cycle.
module rob_retire
    import rob_retire_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = ROB_TAG_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [0:1]                i_dispatch_valid,
    input  rename_struct [0:1]        i_dispatch_data,
    output logic [0:1][TAG_W-1:0]     o_dispatch_tag,
    output logic                      o_stall,
    input  logic [0:2]                i_wb_valid,
    input  logic [0:2][TAG_W-1:0]     i_wb_tag,
    output rob_row_struct [0:2]       o_complete_rob_rows,
    output logic [TAG_W:0]            o_count
);
    localparam int CW = TAG_W + 1;

    logic [DEPTH-1:0]         r_valid;
    logic [DEPTH-1:0]         r_done;
    rename_struct             r_data [DEPTH];
    logic [TAG_W-1:0]         r_head;
    logic [TAG_W-1:0]         r_tail;
    logic [TAG_W:0]           r_count;
    logic                     r_stall;
    logic [0:2]               r_row_vld;
    logic [0:2][TAG_W-1:0]    r_row_tag;
    rename_struct [0:2]       r_row_data;

    logic [0:2][TAG_W-1:0]    w_hidx;
    logic [2:0]               w_hv;
    logic [2:0]               w_hd;
    logic [2:0]               w_mask;
    logic [1:0]               w_ret_n;
    logic [0:1]               w_acc;
    logic [1:0]               w_acc_n;
    logic [TAG_W:0]           w_count_next;

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_hidx[r] = r_head + TAG_W'(r);
            w_hv[r]   = r_valid[w_hidx[r]];
            w_hd[r]   = r_done[w_hidx[r]];
        end
        w_acc             = r_stall ? 2'b00 : i_dispatch_valid;
        w_acc_n           = {1'b0, w_acc[0]} + {1'b0, w_acc[1]};
        o_dispatch_tag[0] = r_tail;
        o_dispatch_tag[1] = r_tail + {{(TAG_W-1){1'b0}}, i_dispatch_valid[0]};
        w_count_next      = r_count + CW'(w_acc_n) - CW'(w_ret_n);
    end

    rob_retire_select u_select (
        .i_valid (w_hv),
        .i_done  (w_hd),
        .o_mask  (w_mask),
        .o_count (w_ret_n)
    );

    // Control state; later assignments win, so retire/dispatch clears override writeback.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_stall   <= 1'b0;
            r_valid   <= '0;
            r_done    <= '0;
            r_row_vld <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (i_wb_valid[k] && r_valid[i_wb_tag[k]]) begin
                    r_done[i_wb_tag[k]] <= 1'b1;
                end
            end
            for (int r = 0; r < 3; r++) begin
                r_row_vld[r] <= w_mask[r];
                if (w_mask[r]) begin
                    r_valid[w_hidx[r]] <= 1'b0;
                    r_done[w_hidx[r]]  <= 1'b0;
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (w_acc[k]) begin
                    r_valid[o_dispatch_tag[k]] <= 1'b1;
                    r_done[o_dispatch_tag[k]]  <= 1'b0;
                end
            end
            r_head  <= r_head + TAG_W'(w_ret_n);
            r_tail  <= r_tail + TAG_W'(w_acc_n);
            r_count <= w_count_next;
            r_stall <= (w_count_next > CW'(DEPTH - 2));
        end
    end

    // Payload storage and retired-row data carry no reset; row validity qualifies them.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 2; k++) begin
            if (w_acc[k]) begin
                r_data[o_dispatch_tag[k]] <= i_dispatch_data[k];
            end
        end
        for (int r = 0; r < 3; r++) begin
            r_row_tag[r]  <= w_hidx[r];
            r_row_data[r] <= r_data[w_hidx[r]];
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            o_complete_rob_rows[r].valid          = r_row_vld[r];
            o_complete_rob_rows[r].tag            = r_row_tag[r];
            o_complete_rob_rows[r].ArchRegDst     = r_row_data[r].ArchRegDst;
            o_complete_rob_rows[r].PRegAddrDst    = r_row_data[r].PRegAddrDst;
            o_complete_rob_rows[r].OldPRegAddrDst = r_row_data[r].OldPRegAddrDst;
        end
        o_stall = r_stall;
        o_count = r_count;
    end
endmodule

// File: tb/tb_rob_retire.sv
// Self-checking bench for rob_retire against a queue-based reorder buffer model.
module tb_rob_retire;
    import rob_retire_pkg::*;

    localparam int DEPTH = ROB_DEPTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst;
    logic [0:1]                 dv;
    rename_struct [0:1]         dd;
    logic [0:2]                 wv;
    logic [0:2][ROB_TAG_W-1:0]  wt;
    logic [0:1][ROB_TAG_W-1:0]  tag_o;
    logic                       stall_o;
    rob_row_struct [0:2]        rows;
    logic [ROB_TAG_W:0]         count_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int           tag;
        rename_struct d;
        bit           done;
    } ment_t;

    ment_t        mq[$];
    int           m_tail = 0;
    bit           m_stall = 0;
    bit           ev[3];
    int           et[3];
    rename_struct ed[3];
    int           n_acc_total = 0;

    rob_retire dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_dispatch_valid    (dv),
        .i_dispatch_data     (dd),
        .o_dispatch_tag      (tag_o),
        .o_stall             (stall_o),
        .i_wb_valid          (wv),
        .i_wb_tag            (wt),
        .o_complete_rob_rows (rows),
        .o_count             (count_o)
    );

    function automatic rename_struct mk(int a, int p, int o);
        rename_struct s;
        s.ArchRegDst     = AREG_W'(a);
        s.PRegAddrDst    = PREG_W'(p);
        s.OldPRegAddrDst = PREG_W'(o);
        return s;
    endfunction

    // Advance the model by one edge using the currently driven inputs, then clock the DUT.
    task automatic step();
        int    n;
        ment_t e;
        if (rst) begin
            mq.delete();
            m_tail  = 0;
            m_stall = 0;
            for (int r = 0; r < 3; r++) ev[r] = 0;
        end else begin
            n = 0;
            while (n < 3 && n < mq.size() && mq[n].done) n++;
            for (int r = 0; r < 3; r++) begin
                ev[r] = (r < n);
                if (r < n) begin
                    et[r] = mq[r].tag;
                    ed[r] = mq[r].d;
                end
            end
            repeat (n) void'(mq.pop_front());
            for (int k = 0; k < 3; k++)
                if (wv[k])
                    foreach (mq[i]) if (mq[i].tag == int'(wt[k])) mq[i].done = 1;
            if (!m_stall) begin
                for (int k = 0; k < 2; k++) begin
                    if (dv[k]) begin
                        e.tag  = m_tail;
                        e.d    = dd[k];
                        e.done = 0;
                        mq.push_back(e);
                        m_tail = (m_tail + 1) % DEPTH;
                        n_acc_total++;
                    end
                end
            end
            m_stall = mq.size() > DEPTH - 2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; dv = '0; dd = '0; wv = '0; wt = '0;
        step(); step();
        rst = 0;
        #1;
        checks++;
        if (count_o !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++;
        if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall_o); end
        for (int r = 0; r < 3; r++) begin
            checks++;
            if (rows[r].valid !== 1'b0) begin failures++; $display("FAIL reset_row%0d_valid got=%0b exp=0", r, rows[r].valid); end
        end
        checks++;
        if (tag_o[0] !== 6'd0) begin failures++; $display("FAIL reset_tag0 got=%0d exp=0", tag_o[0]); end
    endtask

    task automatic test_basic_retire();
        dd[0] = mk(1, 40, 5); dd[1] = mk(2, 41, 6); dv = 2'b11;
        #1;
        checks++;
        if (tag_o[1] !== 6'd1) begin failures++; $display("FAIL basic_tag1 got=%0d exp=1", tag_o[1]); end
        step();
        dv = '0; wv = 3'b110; wt[0] = 6'd0; wt[1] = 6'd1;
        step();
        wv = '0;
        step();
        checks++;
        if (rows[0].valid !== 1'b1 || rows[0].OldPRegAddrDst !== 7'd5 || rows[0].tag !== 6'd0)
            begin failures++; $display("FAIL basic_row0 got=v%0b old%0d t%0d exp=v1 old5 t0", rows[0].valid, rows[0].OldPRegAddrDst, rows[0].tag); end
        checks++;
        if (rows[1].valid !== 1'b1 || rows[1].OldPRegAddrDst !== 7'd6 || rows[1].PRegAddrDst !== 7'd41)
            begin failures++; $display("FAIL basic_row1 got=v%0b old%0d dst%0d exp=v1 old6 dst41", rows[1].valid, rows[1].OldPRegAddrDst, rows[1].PRegAddrDst); end
        checks++;
        if (rows[2].valid !== 1'b0) begin failures++; $display("FAIL basic_row2 got=%0b exp=0", rows[2].valid); end
        checks++;
        if (count_o !== '0) begin failures++; $display("FAIL basic_count got=%0d exp=0", count_o); end
    endtask

    task automatic test_prefix();
        logic [ROB_TAG_W-1:0] base;
        base = ROB_TAG_W'(m_tail);
        dv = 2'b11; dd[0] = mk(3, 50, 10); dd[1] = mk(4, 51, 11);
        step();
        dv = 2'b10; dd[0] = mk(5, 52, 12);
        step();
        dv = '0; wv = 3'b110; wt[0] = base + 6'd1; wt[1] = base + 6'd2;
        step();
        wv = '0;
        step();
        for (int r = 0; r < 3; r++) begin
            checks++;
            if (rows[r].valid !== 1'b0) begin failures++; $display("FAIL prefix_hold_row%0d got=%0b exp=0", r, rows[r].valid); end
        end
        checks++;
        if (count_o !== 7'd3) begin failures++; $display("FAIL prefix_count3 got=%0d exp=3", count_o); end
        wv = 3'b100; wt[0] = base;
        step();
        wv = '0;
        checks++;
        if (rows[0].valid !== 1'b0) begin failures++; $display("FAIL prefix_wb_latency got=%0b exp=0", rows[0].valid); end
        step();
        for (int r = 0; r < 3; r++) begin
            checks++;
            if (rows[r].valid !== 1'b1 || rows[r].tag !== base + ROB_TAG_W'(r) || rows[r].OldPRegAddrDst !== PREG_W'(10 + r))
                begin failures++; $display("FAIL prefix_row%0d got=v%0b t%0d old%0d exp=v1 t%0d old%0d", r, rows[r].valid, rows[r].tag, rows[r].OldPRegAddrDst, base + ROB_TAG_W'(r), 10 + r); end
        end
        checks++;
        if (count_o !== '0) begin failures++; $display("FAIL prefix_count0 got=%0d exp=0", count_o); end
    endtask

    task automatic test_stall();
        int guard;
        logic [ROB_TAG_W-1:0] t;
        guard = 0;
        while (!m_stall && guard < 40) begin
            dv = 2'b11;
            dd[0] = mk($urandom_range(0, 31), $urandom_range(0, 127), $urandom_range(0, 127));
            dd[1] = mk($urandom_range(0, 31), $urandom_range(0, 127), $urandom_range(0, 127));
            step();
            guard++;
        end
        dv = '0;
        checks++;
        if (stall_o !== 1'b1) begin failures++; $display("FAIL stall_set got=%0b exp=1", stall_o); end
        checks++;
        if (count_o !== 7'(DEPTH)) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", count_o, DEPTH); end
        t = ROB_TAG_W'(m_tail);
        dv = 2'b11;
        step();
        checks++;
        if (count_o !== 7'(DEPTH)) begin failures++; $display("FAIL stall_ignore_count got=%0d exp=%0d", count_o, DEPTH); end
        checks++;
        if (tag_o[0] !== t) begin failures++; $display("FAIL stall_ignore_tail got=%0d exp=%0d", tag_o[0], t); end
        dv = '0;
        wv = 3'b111;
        for (int k = 0; k < 3; k++) wt[k] = ROB_TAG_W'(mq[k].tag);
        step();
        wv = '0;
        step();
        for (int r = 0; r < 3; r++) begin
            checks++;
            if (rows[r].valid !== 1'b1 || int'(rows[r].tag) != et[r])
                begin failures++; $display("FAIL stall_retire_row%0d got=v%0b t%0d exp=v1 t%0d", r, rows[r].valid, rows[r].tag, et[r]); end
        end
        checks++;
        if (count_o !== 7'(DEPTH - 3) || stall_o !== 1'b0)
            begin failures++; $display("FAIL stall_release got=c%0d s%0b exp=c%0d s0", count_o, stall_o, DEPTH - 3); end
    endtask

    task automatic test_wrap();
        int start, cyc;
        start = n_acc_total;
        cyc = 0;
        while ((n_acc_total - start < 200 || mq.size() > 0) && cyc < 4000) begin
            dv = (n_acc_total - start < 200) ? 2'($urandom) : 2'b00;
            dd[0] = mk($urandom_range(0, 31), $urandom_range(0, 127), $urandom_range(0, 127));
            dd[1] = mk($urandom_range(0, 31), $urandom_range(0, 127), $urandom_range(0, 127));
            for (int k = 0; k < 3; k++) begin
                if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                    wv[k] = 1'b1;
                    wt[k] = ROB_TAG_W'(mq[$urandom_range(0, mq.size() - 1)].tag);
                end else if ($urandom_range(0, 7) == 0) begin
                    wv[k] = 1'b1;
                    wt[k] = ROB_TAG_W'($urandom);
                end else begin
                    wv[k] = 1'b0;
                end
            end
            #1;
            checks++;
            if (int'(tag_o[0]) != m_tail || int'(tag_o[1]) != (m_tail + int'(dv[0])) % DEPTH)
                begin failures++; $display("FAIL wrap_tags got=%0d,%0d exp=%0d,%0d", tag_o[0], tag_o[1], m_tail, (m_tail + int'(dv[0])) % DEPTH); end
            step();
            for (int r = 0; r < 3; r++) begin
                checks++;
                if (rows[r].valid !== ev[r] || (ev[r] && (int'(rows[r].tag) != et[r] ||
                    rows[r].PRegAddrDst !== ed[r].PRegAddrDst || rows[r].OldPRegAddrDst !== ed[r].OldPRegAddrDst ||
                    rows[r].ArchRegDst !== ed[r].ArchRegDst)))
                    begin failures++; $display("FAIL wrap_row%0d cyc=%0d got=v%0b t%0d exp=v%0b t%0d", r, cyc, rows[r].valid, rows[r].tag, ev[r], et[r]); end
            end
            checks++;
            if (int'(count_o) != mq.size() || stall_o !== m_stall)
                begin failures++; $display("FAIL wrap_occ cyc=%0d got=c%0d s%0b exp=c%0d s%0b", cyc, count_o, stall_o, mq.size(), m_stall); end
            cyc++;
        end
        dv = '0; wv = '0;
        checks++;
        if (cyc >= 4000) begin failures++; $display("FAIL wrap_timeout got=%0d exp=<4000", cyc); end
        checks++;
        if (count_o !== '0) begin failures++; $display("FAIL wrap_drain_count got=%0d exp=0", count_o); end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 5; i++) begin
            dv = 2'b11;
            dd[0] = mk(i, 60 + i, i);
            dd[1] = mk(i, 70 + i, i);
            step();
        end
        dv = '0; wv = 3'b111;
        wt[0] = ROB_TAG_W'(mq[0].tag); wt[1] = ROB_TAG_W'(mq[1].tag); wt[2] = ROB_TAG_W'(mq[4].tag);
        step();
        wv = '0; rst = 1;
        step();
        rst = 0;
        for (int r = 0; r < 3; r++) begin
            checks++;
            if (rows[r].valid !== 1'b0) begin failures++; $display("FAIL midrst_row%0d got=%0b exp=0", r, rows[r].valid); end
        end
        checks++;
        if (count_o !== '0 || stall_o !== 1'b0) begin failures++; $display("FAIL midrst_occ got=c%0d s%0b exp=c0 s0", count_o, stall_o); end
        dv = 2'b10; dd[0] = mk(7, 33, 22);
        #1;
        checks++;
        if (tag_o[0] !== 6'd0) begin failures++; $display("FAIL midrst_newtag got=%0d exp=0", tag_o[0]); end
        step();
        dv = '0; wv = 3'b100; wt[0] = 6'd0;
        step();
        wv = '0;
        step();
        checks++;
        if (rows[0].valid !== 1'b1 || rows[0].tag !== 6'd0 || rows[0].OldPRegAddrDst !== 7'd22 || count_o !== '0)
            begin failures++; $display("FAIL midrst_retire got=v%0b t%0d old%0d c%0d exp=v1 t0 old22 c0", rows[0].valid, rows[0].tag, rows[0].OldPRegAddrDst, count_o); end
    endtask

    task automatic test_wb_corner();
        dv = 2'b11; dd[0] = mk(1, 11, 0); dd[1] = mk(2, 0, 0);
        step();
        dv = '0; wv = 3'b111; wt[0] = 6'd1; wt[1] = 6'd1; wt[2] = 6'd9;
        step();
        wv = '0;
        step();
        checks++;
        if (rows[0].valid !== 1'b1 || rows[0].tag !== 6'd1 || rows[1].valid !== 1'b0 || rows[2].valid !== 1'b0 || count_o !== 7'd1)
            begin failures++; $display("FAIL wbc_first got=v%0b%0b%0b t%0d c%0d exp=v100 t1 c1", rows[0].valid, rows[1].valid, rows[2].valid, rows[0].tag, count_o); end
        wv = 3'b111; wt[0] = 6'd2; wt[1] = 6'd2; wt[2] = 6'd1;
        step();
        wv = '0;
        step();
        checks++;
        if (rows[0].valid !== 1'b1 || rows[0].tag !== 6'd2 || rows[0].PRegAddrDst !== 7'd0 || rows[1].valid !== 1'b0 || count_o !== '0)
            begin failures++; $display("FAIL wbc_nodst got=v%0b%0b t%0d c%0d exp=v10 t2 c0", rows[0].valid, rows[1].valid, rows[0].tag, count_o); end
        step();
        checks++;
        if (rows[0].valid !== 1'b0 || rows[1].valid !== 1'b0 || rows[2].valid !== 1'b0 || count_o !== '0)
            begin failures++; $display("FAIL wbc_once got=v%0b%0b%0b c%0d exp=v000 c0", rows[0].valid, rows[1].valid, rows[2].valid, count_o); end
    endtask

    initial begin
        test_reset();
        test_basic_retire();
        test_prefix();
        test_stall();
        test_wrap();
        test_reset_midflight();
        test_wb_corner();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
